// File: rtl/bram_bank_arbiter_pkg.sv
// Shared helpers for the BRAM bank arbiter: width calculation and address-window decode.
package bank_arb_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

  // Requester id width, never narrower than one bit.
  function automatic int unsigned req_id_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] lo,
                                     input logic [63:0] hi);
    return (lo <= addr) && (addr <= hi);
  endfunction

endpackage

// File: rtl/bram_bank_arbiter_if.sv
// Engine-side request/response bus of one BRAM bank arbiter.
interface bram_bank_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_grant;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_grant, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_grant, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter
  import bank_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req,
  input  logic                     advance,
  output logic [N-1:0]             gnt,
  output logic [req_id_w(N)-1:0]   gnt_id
);
  localparam int unsigned W = req_id_w(N);

  logic [W-1:0] ptr;
  logic [N-1:0] upperMask;
  logic [N-1:0] upperReq;
  logic [N-1:0] pick;
  logic         found;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    upperMask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      upperMask[i] = (32'(ptr) <= i);
    end
    upperReq = req & upperMask;
    pick     = (|upperReq) ? upperReq : req;
  end

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && pick[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_id == W'(N - 1)) ? '0 : gnt_id + W'(1);
    end
  end

endmodule

// File: rtl/bram_bank_arbiter.sv
// Shares one single-port BRAM bank between NUM_REQ engines: window decode,
// round-robin grant, registered memory command and read-return routing.
module bram_bank_arbiter
  import bank_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOWER_ADDR = 0,
  parameter int unsigned UPPER_ADDR = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_bank_arbiter_if.slave    reqBus,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  conflict
);
  localparam int unsigned W = req_id_w(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LowerLocal = ADDR_WIDTH'(LOWER_ADDR);

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    gnt;
  logic [W-1:0]          gntId;
  logic                  transfer;
  logic                  selWe;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;

  logic                  tagValid [RD_LATENCY];
  logic [W-1:0]          tagId    [RD_LATENCY];
  logic [NUM_REQ-1:0]    rspValidQ;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = reqBus.req_valid[i] &
                    in_window(64'(reqBus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
                              64'(LOWER_ADDR), 64'(UPPER_ADDR));
    end
  end

  rr_arbiter #(.N(NUM_REQ)) uArb (
    .clk     (clk),
    .rst     (rst),
    .req     (eligible),
    .advance (|eligible),
    .gnt     (gnt),
    .gnt_id  (gntId)
  );

  assign transfer = |gnt;

  always_comb begin
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        selWe    = reqBus.req_we[i];
        selAddr  = reqBus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        selWdata = reqBus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      conflict  <= 1'b0;
    end else begin
      mem_en   <= transfer;
      mem_we   <= transfer & selWe;
      conflict <= ($countones(eligible) > 1);
      if (transfer) begin
        mem_addr  <= selAddr - LowerLocal;
        mem_wdata <= selWdata;
      end
    end
  end

  // Tag stage 0 lines up with mem_en; the extra rspValidQ stage lines up with mem_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < RD_LATENCY; s++) begin
        tagValid[s] <= 1'b0;
        tagId[s]    <= '0;
      end
      rspValidQ <= '0;
    end else begin
      tagValid[0] <= transfer & ~selWe;
      tagId[0]    <= gntId;
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        tagValid[s] <= tagValid[s-1];
        tagId[s]    <= tagId[s-1];
      end
      rspValidQ <= tagValid[RD_LATENCY-1] ? (NUM_REQ'(1) << tagId[RD_LATENCY-1]) : '0;
    end
  end

  assign reqBus.req_grant = gnt;
  assign reqBus.rsp_valid = rspValidQ;
  assign reqBus.rsp_data  = (|rspValidQ) ? mem_rdata : '0;

endmodule
